tof_exposure_seq: RTL and testbench
===================================

# tof_exposure_seq

Exposure window sequencer directly upstream of the three-clock ToF modulation generator. Produces that generator's VALID window and a stable PERIOD value. Each window lasts an exact integer number of modulation periods, and a programmable count of windows is separated by idle gaps. Host logic starts it with a single-cycle START pulse and observes BUSY/DONE/ERR.

## Interface
- CNT_W, 32: width of PERIOD, NUM_PULSES, GAP counters.
- EXP_W, 16: width of NUM_EXP and EXP_IDX.

- CLKIN  in  1  system clock; all logic on rising edge.
- RST  in  1  asynchronous, active-high reset.
- START  in  1  single-cycle start request; honoured only in IDLE.
- ABORT  in  1  level/pulse; returns to IDLE next edge.
- PERIOD  in  CNT_W  modulation period in CLKIN cycles.
- NUM_PULSES  in  CNT_W  modulation periods per window.
- GAP  in  CNT_W  low cycles between windows.
- NUM_EXP  in  EXP_W  windows per sequence.
- VALID  out  1  exposure window; drives the modulation generator's VALID.
- PERIOD_OUT  out  CNT_W  period value for the modulation generator.
- BUSY  out  1  high while not IDLE.
- DONE  out  1  one-cycle pulse at normal sequence completion.
- ERR  out  1  sticky config error; cleared by next accepted START.
- EXP_IDX  out  EXP_W  index of current/last window, 0-based.

## Operation
- States: IDLE, ON, GAP, FIN.
- IDLE + START:
  - Latch PERIOD, NUM_PULSES, GAP, NUM_EXP.
  - Clear ERR and EXP_IDX.
  - If any latched PERIOD, NUM_PULSES or NUM_EXP equals 0, go to FIN with ERR=1 and VALID never asserted.
  - Otherwise go to ON.
- ON:
  - VALID=1.
  - Period counter pc counts 0..PERIOD-1. Pulse counter nc increments on pc wrap.
  - After nc reaches NUM_PULSES, the window has lasted exactly PERIOD×NUM_PULSES cycles. No multiplier is used.
  - Then: if EXP_IDX==NUM_EXP-1, go to FIN. Otherwise go to GAP.
- GAP:
  - VALID=0 for max(GAP,1) cycles. A GAP of 0 is forced to 1 so the downstream posedge resync always sees an edge.
  - Then EXP_IDX increments and the state returns to ON.
- FIN: DONE=1 for one cycle, BUSY=0, then IDLE.
- START in any non-IDLE state is ignored.
- ABORT in any state:
  - Next edge enters IDLE with VALID=0 and BUSY=0.
  - DONE is not pulsed, ERR is unchanged, EXP_IDX holds.
- START and ABORT in the same cycle: ABORT wins and nothing is latched.
- Counters compare with equality on latched values. Input changes during a sequence have no effect.
- EXP_IDX never wraps within a sequence, because it is bounded by NUM_EXP.

## Timing
- Reset values: VALID=0, BUSY=0, DONE=0, ERR=0, EXP_IDX=0, PERIOD_OUT=0, state IDLE, counters 0.
- All outputs are registered.
- Start latency: START sampled at edge k gives VALID=1 and BUSY=1 from edge k+1.
- ON length exactly PERIOD×NUM_PULSES cycles. GAP length exactly max(GAP,1) cycles.
- Completion: the edge that ends the final window sets VALID=0 and DONE=1 together; BUSY=0 in that same cycle. The next edge gives DONE=0.
- Config error: START at edge k gives DONE=1 and ERR=1 at edge k+1. BUSY stays 0 and VALID stays 0.
- Back-to-back: START is accepted in the cycle DONE is high, because the state is FIN and behaves as IDLE for acceptance. VALID then rises the next edge.

## Configuration
- TOFSEQ_PERIOD_HOLD_EN defined:
  - PERIOD_OUT is the value latched at accepted START.
  - It is stable for the whole sequence and holds after completion.
- Not defined:
  - PERIOD_OUT = PERIOD combinationally. Reset value is not applicable.
  - The host must keep PERIOD constant while BUSY.
  - Sequencer timing always uses the latched copy either way.

## Test plan
- PERIOD=4, NUM_PULSES=3, GAP=5, NUM_EXP=2, START pulse -> VALID high 12 cycles, low 5, high 12. DONE is one cycle on the final fall. EXP_IDX goes 0 then 1.
- GAP=0, PERIOD=2, NUM_PULSES=1, NUM_EXP=3 -> VALID pattern is 2 high / 1 low repeated, with exactly three rising edges.
- NUM_PULSES=0 -> DONE=1 and ERR=1 one cycle after START. VALID never rises. ERR clears on the next valid START.
- ABORT mid-ON at the 5th cycle of a 12-cycle window -> VALID=0 and BUSY=0 next edge, no DONE. START is then accepted normally.
- Assert RST asynchronously mid-GAP -> all outputs go to reset values immediately. START during BUSY is ignored, and START+ABORT together latches nothing.
- With TOFSEQ_PERIOD_HOLD_EN: change PERIOD from 4 to 9 while BUSY -> PERIOD_OUT stays 4 and the window length is unchanged. Without the macro, PERIOD_OUT follows 9 immediately.

Source files
------------

// File: rtl/tof_exposure_seq.sv
// Exposure window sequencer feeding the ToF modulation generator: emits N windows of
// PERIOD*NUM_PULSES cycles separated by idle gaps. Optional macro TOFSEQ_PERIOD_HOLD_EN.
module tof_exposure_seq #(
  parameter int CNT_W = 32,
  parameter int EXP_W = 16
) (
  input  logic             clkin,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic [CNT_W-1:0] period,
  input  logic [CNT_W-1:0] num_pulses,
  input  logic [CNT_W-1:0] gap,
  input  logic [EXP_W-1:0] num_exp,
  output logic             valid,
  output logic [CNT_W-1:0] period_out,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [EXP_W-1:0] exp_idx
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ON,
    S_GAP,
    S_FIN
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] per_q;
  logic [CNT_W-1:0] np_q;
  logic [CNT_W-1:0] gap_last_q;
  logic [EXP_W-1:0] nexp_q;
  logic [CNT_W-1:0] pc;
  logic [CNT_W-1:0] nc;
  logic [CNT_W-1:0] gc;

  logic cfg_bad;
  logic pc_wrap;
  logic win_end;
  logic last_win;
  logic gap_end;

  assign cfg_bad  = (period == '0) || (num_pulses == '0) || (num_exp == '0);
  assign pc_wrap  = (pc == per_q - CNT_W'(1));
  assign win_end  = pc_wrap && (nc == np_q - CNT_W'(1));
  assign last_win = (exp_idx == nexp_q - EXP_W'(1));
  assign gap_end  = (gc == gap_last_q);

`ifdef TOFSEQ_PERIOD_HOLD_EN
  assign period_out = per_q;
`else
  assign period_out = period;
`endif

  // NOTE: sequential state uses non-blocking assignments only, so every register in this
  // block sees the pre-edge values of the others regardless of statement order.
  always_ff @(posedge clkin or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      per_q      <= '0;
      np_q       <= '0;
      gap_last_q <= '0;
      nexp_q     <= '0;
      pc         <= '0;
      nc         <= '0;
      gc         <= '0;
      valid      <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
      exp_idx    <= '0;
    end else begin
      done <= 1'b0;
      if (abort) begin
        state <= S_IDLE;
        valid <= 1'b0;
        busy  <= 1'b0;
      end else begin
        unique case (state)
          S_IDLE, S_FIN: begin
            // FIN accepts a new START so sequences can run back to back.
            if (start) begin
              per_q      <= period;
              np_q       <= num_pulses;
              gap_last_q <= (gap == '0) ? '0 : gap - CNT_W'(1);
              nexp_q     <= num_exp;
              exp_idx    <= '0;
              pc         <= '0;
              nc         <= '0;
              gc         <= '0;
              if (cfg_bad) begin
                state <= S_FIN;
                done  <= 1'b1;
                err   <= 1'b1;
                valid <= 1'b0;
                busy  <= 1'b0;
              end else begin
                state <= S_ON;
                err   <= 1'b0;
                valid <= 1'b1;
                busy  <= 1'b1;
              end
            end else begin
              state <= S_IDLE;
            end
          end

          S_ON: begin
            if (pc_wrap) begin
              pc <= '0;
              nc <= nc + CNT_W'(1);
            end else begin
              pc <= pc + CNT_W'(1);
            end
            // Nested period/pulse counters give PERIOD*NUM_PULSES cycles without a multiplier.
            if (win_end) begin
              valid <= 1'b0;
              nc    <= '0;
              gc    <= '0;
              if (last_win) begin
                state <= S_FIN;
                done  <= 1'b1;
                busy  <= 1'b0;
              end else begin
                state <= S_GAP;
              end
            end
          end

          S_GAP: begin
            if (gap_end) begin
              state   <= S_ON;
              valid   <= 1'b1;
              pc      <= '0;
              nc      <= '0;
              exp_idx <= exp_idx + EXP_W'(1);
            end else begin
              gc <= gc + CNT_W'(1);
            end
          end

          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_tof_exposure_seq.sv
// Self-checking bench for tof_exposure_seq: phase-duration model checked every cycle,
// plus directed scenarios with hand-computed counts. Honours TOFSEQ_PERIOD_HOLD_EN.
module tb_tof_exposure_seq;

  logic        clkin = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic [31:0] period = '0;
  logic [31:0] num_pulses = '0;
  logic [31:0] gap = '0;
  logic [15:0] num_exp = '0;
  logic        valid;
  logic [31:0] period_out;
  logic        busy;
  logic        done;
  logic        err;
  logic [15:0] exp_idx;

  tof_exposure_seq dut (
    .clkin      (clkin),
    .rst        (rst),
    .start      (start),
    .abort      (abort),
    .period     (period),
    .num_pulses (num_pulses),
    .gap        (gap),
    .num_exp    (num_exp),
    .valid      (valid),
    .period_out (period_out),
    .busy       (busy),
    .done       (done),
    .err        (err),
    .exp_idx    (exp_idx)
  );

  always #5 clkin = ~clkin;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model: tracks the remaining length of the current phase, using the product directly.
  localparam int PH_IDLE = 0, PH_ON = 1, PH_GAP = 2, PH_FIN = 3;
  int              m_phase = PH_IDLE;
  longint unsigned m_remain = 0;
  logic            m_valid = 0, m_busy = 0, m_done = 0, m_err = 0;
  logic [15:0]     m_idx = 0, m_ne = 0;
  logic [31:0]     m_p = 0, m_n = 0, m_g = 0, m_pout = 0;

  always @(posedge clkin) begin
    if (rst) begin
      m_phase = PH_IDLE; m_remain = 0; m_valid = 0; m_busy = 0; m_done = 0;
      m_err = 0; m_idx = 0; m_pout = 0;
    end else if (abort) begin
      m_phase = PH_IDLE; m_valid = 0; m_busy = 0; m_done = 0;
    end else if ((m_phase == PH_IDLE || m_phase == PH_FIN) && start) begin
      m_p = period; m_n = num_pulses; m_g = gap; m_ne = num_exp;
      m_pout = period; m_idx = 0;
      if (m_p == 0 || m_n == 0 || m_ne == 0) begin
        m_phase = PH_FIN; m_done = 1; m_err = 1; m_valid = 0; m_busy = 0;
      end else begin
        m_phase = PH_ON; m_remain = longint'(m_p) * longint'(m_n);
        m_done = 0; m_err = 0; m_valid = 1; m_busy = 1;
      end
    end else begin
      m_done = 0;
      case (m_phase)
        PH_FIN: m_phase = PH_IDLE;
        PH_ON: begin
          m_remain--;
          if (m_remain == 0) begin
            m_valid = 0;
            if (int'(m_idx) + 1 == int'(m_ne)) begin
              m_phase = PH_FIN; m_done = 1; m_busy = 0;
            end else begin
              m_phase = PH_GAP; m_remain = (m_g == 0) ? 1 : longint'(m_g);
            end
          end
        end
        PH_GAP: begin
          m_remain--;
          if (m_remain == 0) begin
            m_phase = PH_ON; m_valid = 1; m_idx++;
            m_remain = longint'(m_p) * longint'(m_n);
          end
        end
        default: ;
      endcase
    end
    #1;
    check("cyc valid", valid, m_valid);
    check("cyc busy", busy, m_busy);
    check("cyc done", done, m_done);
    check("cyc err", err, m_err);
    check("cyc exp_idx", exp_idx, m_idx);
`ifdef TOFSEQ_PERIOD_HOLD_EN
    check("cyc period_out", period_out, m_pout);
`else
    check("cyc period_out", period_out, period);
`endif
  end

  int   highs = 0, rises = 0, dones = 0;
  logic prev_v = 1'b0;

  task automatic step();
    @(posedge clkin);
    #2;
    if (valid && !prev_v) rises++;
    if (valid) highs++;
    if (done) dones++;
    prev_v = valid;
  endtask

  task automatic clr();
    highs = 0; rises = 0; dones = 0;
  endtask

  task automatic wait_done(input int budget, input string name);
    int k = 0;
    while (!done && k < budget) begin
      step();
      k++;
    end
    check({name, " done within budget"}, done, 1'b1);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  initial begin
    repeat (2) step();
    check("reset valid", valid, 0);
    check("reset busy", busy, 0);
    check("reset done", done, 0);
    check("reset err", err, 0);
    check("reset exp_idx", exp_idx, 0);
`ifdef TOFSEQ_PERIOD_HOLD_EN
    check("reset period_out", period_out, 0);
`endif
    rst = 1'b0;
    step();

    // Two 12-cycle windows, 5-cycle gap
    period = 4; num_pulses = 3; gap = 5; num_exp = 2;
    clr();
    pulse_start();
    check("t1 start valid", valid, 1);
    check("t1 start busy", busy, 1);
    wait_done(60, "t1");
    check("t1 high cycles", highs, 24);
    check("t1 rises", rises, 2);
    check("t1 done pulses", dones, 1);
    check("t1 final idx", exp_idx, 1);
    check("t1 busy at done", busy, 0);

    // Back-to-back start while DONE is high; GAP=0 forced to one cycle
    period = 2; num_pulses = 1; gap = 0; num_exp = 3;
    clr();
    pulse_start();
    check("b2b valid", valid, 1);
    wait_done(40, "t2");
    check("t2 rises", rises, 3);
    check("t2 high cycles", highs, 6);
    check("t2 final idx", exp_idx, 2);
    step();

    // Config error
    num_pulses = 0;
    clr();
    pulse_start();
    check("cfg done", done, 1);
    check("cfg err", err, 1);
    check("cfg busy", busy, 0);
    step();
    check("cfg done drop", done, 0);
    check("cfg err sticky", err, 1);
    repeat (3) step();
    check("cfg no valid", highs, 0);

    // Abort in 5th cycle of a 12-cycle window; ERR cleared by the valid START
    period = 4; num_pulses = 3; gap = 5; num_exp = 2;
    pulse_start();
    check("t4 err cleared", err, 0);
    repeat (4) step();
    check("t4 still on", valid, 1);
    abort = 1'b1;
    step();
    abort = 1'b0;
    check("abort valid", valid, 0);
    check("abort busy", busy, 0);
    check("abort done", done, 0);
    clr();
    repeat (3) step();
    check("abort no done", dones, 0);
    check("abort stays low", highs, 0);

    // Restart, ignored START while busy, async reset mid-gap
    pulse_start();
    check("t5 valid", valid, 1);
    repeat (2) step();
    period = 7; num_pulses = 1;
    pulse_start();
    check("t5 ignored start idx", exp_idx, 0);
    check("t5 ignored start valid", valid, 1);
    begin
      int k = 0;
      while (valid && k < 40) begin
        step();
        k++;
      end
    end
    check("t5 reached gap", valid, 0);
    check("t5 gap busy", busy, 1);
    step();
    #1 rst = 1'b1;
    #1;
    check("async rst valid", valid, 0);
    check("async rst busy", busy, 0);
    check("async rst done", done, 0);
    check("async rst err", err, 0);
    check("async rst idx", exp_idx, 0);
`ifdef TOFSEQ_PERIOD_HOLD_EN
    check("async rst period_out", period_out, 0);
`endif
    step();
    rst = 1'b0;
    step();

    // START and ABORT together latch nothing
    period = 4; num_pulses = 3; gap = 1; num_exp = 1;
    start = 1'b1; abort = 1'b1;
    step();
    start = 1'b0; abort = 1'b0;
    check("sa valid", valid, 0);
    check("sa busy", busy, 0);
    check("sa done", done, 0);
`ifdef TOFSEQ_PERIOD_HOLD_EN
    check("sa period_out", period_out, 0);
`endif
    step();
    check("sa still idle", busy, 0);

    // PERIOD change while busy
    clr();
    pulse_start();
    period = 9;
    step();
`ifdef TOFSEQ_PERIOD_HOLD_EN
    check("hold period_out", period_out, 4);
`else
    check("follow period_out", period_out, 9);
`endif
    wait_done(40, "t6");
    check("t6 window length", highs, 12);
    step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
